sram_arbiter: RTL

Parametrised external-SRAM controller and arbiter. It lets NCH pipeline requesters share one asynchronous 16-bit SRAM chip instead of one dedicated chip per memory stage. It sits between the instruction-fetch/data-memory stages and the Ram_* pads. It sequences the chip-enable, output-enable and write-enable strobes with configurable wait states and returns per-channel stall and ack signals to the pipeline.

---
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - NCH-channel arbiter and strobe sequencer for one asynchronous 16-bit SRAM
// Grants one requester per IDLE cycle, holds the access strobe WAIT_CYC+1 cycles, then pulses Ack.
module sram_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 18,
  parameter int NCH       = 2,
  parameter int WAIT_CYC  = 0,
  parameter int PRIO_MODE = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NCH-1:0]           Req,
  input  logic [NCH-1:0]           We,
  input  logic [NCH*ADDR_W-1:0]    Addr,
  input  logic [NCH*DATA_W-1:0]    WData,
  output logic [NCH-1:0]           Ack,
  output logic [DATA_W-1:0]        RData,
  output logic [NCH-1:0]           Busy,
  output logic                     Ram_EN,
  output logic                     Ram_OE,
  output logic                     Ram_WE,
  output logic [ADDR_W-1:0]        Ram_address,
  inout  wire  [DATA_W-1:0]        Ram_data
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IW-1:0]       sel;
  logic [IW-1:0]       cand;
  logic                found;
  logic                we_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic                drive_data;

  // Fixed mode: last matching index wins; round-robin walks from rr+1 with wrap.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = rr_q;
    if (PRIO_MODE == 1) begin
      for (int i = 0; i < NCH; i++) begin
        if (Req[i]) sel = IW'(i);
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cand = (cand >= IW'(NCH - 1)) ? '0 : cand + 1'b1;
        if (!found && Req[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == IW'(i)) begin
        we_sel    = We[i];
        addr_sel  = Addr[i*ADDR_W +: ADDR_W];
        wdata_sel = WData[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|Req) begin
          gnt_d   = sel;
          rr_d    = sel;
          we_d    = we_sel;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          cnt_d   = 4'(WAIT_CYC);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = Ram_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(NCH - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    Ack = '0;
    if (state_q == DONE) begin
      for (int i = 0; i < NCH; i++) Ack[i] = (gnt_q == IW'(i));
    end
  end

  // Strobes decode straight from state so an async reset releases them at once.
  assign Busy        = Req & ~Ack;
  assign RData       = rdata_q;
  assign Ram_address = addr_q;
  assign Ram_EN      = (state_q == IDLE);
  assign Ram_OE      = !((state_q == ACCESS) && !we_q);
  assign Ram_WE      = !((state_q == ACCESS) && we_q);
  assign drive_data  = we_q && ((state_q == ACCESS) || (state_q == DONE));
  assign Ram_data    = drive_data ? wdata_q : {DATA_W{1'bz}};

endmodule
